conv_group_scheduler: RTL
=========================

Name: conv_group_scheduler

Overview:
- Sequences the M-vector manager across all 64 eight-element groups of one convolution pass.
- For each group: issues one element request, pairs each returned element with a filter weight, and multiply-accumulates the products.
- Scales and saturates the sum, then writes one 16-bit result word per group to the result memory.
- Sits between the top-level layer controller (go/done) and the vector manager, filter register file and result RAM.

Parameters:
- NUM_GROUPS, 64, groups per pass; one result word per group; range 1..64.
- GROUP_LEN, 8, elements per group; must match the vector manager's filter vector length.
- FRAC_BITS, 8, arithmetic right shift applied to the accumulator before saturation.
- ACC_W, 36, accumulator width in bits; signed.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- clear  input  1  synchronous, active-high reset.
- go  input  1  start-pass pulse; honoured only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a pass completes.
- m_element_requested  output  1  one-cycle request pulse to the vector manager.
- m_element_ready  input  1  element valid strobe from the vector manager.
- m_element  input  16  signed element from the vector manager.
- filter_index  output  3  current beat index, addressing the filter register file.
- filter_weight  input  16  signed weight; combinational read of filter_index, valid in the same cycle.
- result_address  output  6  result RAM address = group index.
- result_data  output  16  signed saturated result.
- result_write  output  1  one-cycle write strobe.

Behaviour:
- States:
  - IDLE -> REQUEST when go=1.
  - REQUEST (1 cycle) -> STREAM.
  - STREAM -> WRITE on the GROUP_LEN-th accepted beat.
  - WRITE (1 cycle) -> REQUEST if group < NUM_GROUPS-1, else DONE.
  - DONE (1 cycle) -> IDLE.
- REQUEST:
  - m_element_requested=1.
  - acc<=0, beat<=0.
  - On the first pass only (entry from IDLE), group<=0.
- STREAM:
  - Each cycle with m_element_ready=1: acc<=acc+sext(m_element*filter_weight), a signed 16x16->32 product; beat<=beat+1.
  - Cycles with m_element_ready=0 hold all state; no timeout.
- filter_index = beat[2:0], driven combinationally from the register.
- WRITE:
  - result_write=1; result_address=group[5:0].
  - result_data = sat16(acc >>> FRAC_BITS), where >>> is an arithmetic shift (floor; no rounding).
  - sat16 clamps to 32767 / -32768.
  - group<=group+1.
- DONE: done=1, busy=1 for that cycle.
- The vector manager's last_element is not used for group termination; the beat counter alone decides.
- m_element_ready in IDLE, REQUEST, WRITE or DONE is ignored; no accumulation occurs.
- go while busy is ignored; it is not queued.
- clear=1 in any state, including mid-STREAM:
  - next edge: IDLE, acc=0, beat=0, group=0.
  - All outputs 0: busy, done, m_element_requested, result_write, result_data, result_address, filter_index.
  - The caller must also clear the vector manager.
- Reset values: all outputs 0; state IDLE.
- Latency per group: 1 (REQUEST) + stream cycles + 1 (WRITE). With the manager's 2-cycle first-element latency and back-to-back beats, a group takes 11 cycles; a full pass takes 704 cycles + 1 for DONE.
- result_data and result_address are registered, valid only while result_write=1, and hold their values otherwise.

Optional Feature:
- Macro: CONV_GROUP_SCHEDULER_RELU_EN.
- Defined: result_data = max(0, sat16(acc >>> FRAC_BITS)); negative results are written as 0x0000.
- Undefined: the signed saturated value is written unchanged.
- Timing and all other behaviour are identical in both builds.

Test Plan:
- Pass with all weights=0x0100 and all elements=0x0100 (1.0 in Q8) -> 64 writes, addresses 0..63, each data=0x0800; done pulses once; busy falls the cycle after done.
- Element=0x7FFF, weight=0x7FFF for all 8 beats -> result_data=0x7FFF (positive saturation). Element=0x8000, weight=0x7FFF -> 0x8000, or 0x0000 with RELU_EN.
- Beats alternate (1,-1) with weight 0x0100 -> sum 0 -> data 0x0000. A single beat of -1 (0xFFFF) with weight 0x0001 and all others 0 -> acc=-1 -> floor shift -> data 0xFFFF without RELU_EN.
- m_element_ready gapped (1 every 3 cycles) -> accumulation is unchanged, exactly 8 beats are counted per group, and filter_index steps 0..7.
- clear asserted at beat 4 of group 10 -> next cycle all outputs 0, no result_write. A subsequent go restarts at address 0.
- go pulsed mid-pass and m_element_ready pulsed in IDLE -> no effect: the write count is still exactly 64, and the first result after the next go is unaffected.

Source files
------------

// File: rtl/conv_group_scheduler_if.sv
// Bundles the conv_group_scheduler's control, vector-manager, filter-file and result-RAM signals.
// master: the scheduler side. It drives busy/done, the request pulse, filter_index and the result write port.
// slave: the environment side. It drives go, element ready/data and the filter weight.
interface conv_group_scheduler_if;
    logic        go;
    logic        busy;
    logic        done;
    logic        m_element_requested;
    logic        m_element_ready;
    logic [15:0] m_element;
    logic [2:0]  filter_index;
    logic [15:0] filter_weight;
    logic [5:0]  result_address;
    logic [15:0] result_data;
    logic        result_write;

    modport master (
        input  go, m_element_ready, m_element, filter_weight,
        output busy, done, m_element_requested, filter_index,
               result_address, result_data, result_write
    );

    modport slave (
        output go, m_element_ready, m_element, filter_weight,
        input  busy, done, m_element_requested, filter_index,
               result_address, result_data, result_write
    );
endinterface

// File: rtl/conv_group_scheduler.sv
// Purpose: sequences NUM_GROUPS groups of GROUP_LEN element*weight MACs and writes one scaled, saturated word per group.
// Latency: 1 request cycle + stream cycles + 1 write cycle per group; 1 extra DONE cycle per pass.
// Backpressure: the stream stalls indefinitely while m_element_ready is low, with all state held and no timeout.
// Ports: clock/clear (synchronous active-high); bus (master modport) carries go/busy/done, the request and element
//        from the vector manager, filter_index/filter_weight, and result_address/result_data/result_write.
// Build option: CONV_GROUP_SCHEDULER_RELU_EN clamps negative results to 0 before the write.
module conv_group_scheduler #(
    parameter int NUM_GROUPS = 64,
    parameter int GROUP_LEN  = 8,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 36
) (
    input  logic                   clock,
    input  logic                   clear,
    conv_group_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_STREAM,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Signed saturation bounds at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 15'd0};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              beat_q, beat_d;
    logic [5:0]              group_q, group_d;
    logic [15:0]             result_data_q, result_data_d;
    logic [5:0]              result_address_q, result_address_d;

    logic signed [31:0]      elem_ext;
    logic signed [31:0]      wt_ext;
    logic signed [31:0]      product;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shift;
    logic [15:0]             sat_val;
    logic [15:0]             out_val;
    logic                    last_beat;
    logic                    last_group;

    // 16x16 signed product. Both operands are sign-extended, so the low 32 bits are exact.
    assign elem_ext = {{16{bus.m_element[15]}}, bus.m_element};
    assign wt_ext   = {{16{bus.filter_weight[15]}}, bus.filter_weight};
    assign product  = elem_ext * wt_ext;
    assign acc_sum  = acc_q + {{(ACC_W-32){product[31]}}, product};

    // The result is taken from the sum that includes the final beat, so the
    // registered result is ready during the WRITE cycle.
    assign acc_shift = acc_sum >>> FRAC_BITS;

    always_comb begin
        sat_val = acc_shift[15:0];
        if (acc_shift > SAT_MAX) begin
            sat_val = 16'h7FFF;
        end else if (acc_shift < SAT_MIN) begin
            sat_val = 16'h8000;
        end
    end

`ifdef CONV_GROUP_SCHEDULER_RELU_EN
    assign out_val = sat_val[15] ? 16'h0000 : sat_val;
`else
    assign out_val = sat_val;
`endif

    assign last_beat  = (beat_q == 3'(GROUP_LEN - 1));
    assign last_group = (group_q == 6'(NUM_GROUPS - 1));

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        beat_d           = beat_q;
        group_d          = group_q;
        result_data_d    = result_data_q;
        result_address_d = result_address_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    state_d = ST_REQUEST;
                    group_d = 6'd0;
                end
            end
            ST_REQUEST: begin
                acc_d   = '0;
                beat_d  = 3'd0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (bus.m_element_ready) begin
                    acc_d  = acc_sum;
                    beat_d = beat_q + 3'd1;
                    // The beat count alone terminates the group.
                    if (last_beat) begin
                        state_d          = ST_WRITE;
                        result_data_d    = out_val;
                        result_address_d = group_q;
                    end
                end
            end
            ST_WRITE: begin
                group_d = group_q + 6'd1;
                state_d = last_group ? ST_DONE : ST_REQUEST;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q          <= ST_IDLE;
            acc_q            <= '0;
            beat_q           <= 3'd0;
            group_q          <= 6'd0;
            result_data_q    <= 16'd0;
            result_address_q <= 6'd0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            beat_q           <= beat_d;
            group_q          <= group_d;
            result_data_q    <= result_data_d;
            result_address_q <= result_address_d;
        end
    end

    assign bus.busy                = (state_q != ST_IDLE);
    assign bus.done                = (state_q == ST_DONE);
    assign bus.m_element_requested = (state_q == ST_REQUEST);
    assign bus.result_write        = (state_q == ST_WRITE);
    assign bus.filter_index        = beat_q;
    assign bus.result_data         = result_data_q;
    assign bus.result_address      = result_address_q;
endmodule
